// File: rtl/led_matrix_pkg.sv
// Shared constants, scan-state type and pixel helper for the 4x4 LED matrix scanner.
// LED_PWM_EN selects multi-bit PWM pixels; otherwise pixels are 1 bit.
package led_matrix_pkg;
  localparam int unsigned ROWS         = 4;
  localparam int unsigned COLS         = 4;
  localparam int unsigned PIXELS       = ROWS * COLS;
  localparam int unsigned ROW_W        = 2;
  localparam int unsigned COL_W        = 2;
  localparam int unsigned DEF_PWM_BITS = 4;

  // Pixel width for the default PWM_BITS setting
`ifdef LED_PWM_EN
  localparam int unsigned BPP = DEF_PWM_BITS;
`else
  localparam int unsigned BPP = 1;
`endif

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  function automatic int unsigned pixel_index(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
    return 32'(row) * COLS + 32'(col);
  endfunction
endpackage

// File: rtl/led_scan_timer.sv
// Row-slot sequencer: BLANK/ON timing, row counter and PWM slice index.
// LED_PWM_EN enables the slice counter; otherwise slice is tied to zero.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 4096,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned SLICE_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output scan_state_t           state,
  output logic [ROW_W-1:0]      row,
  output logic [SLICE_BITS-1:0] slice,
  output logic                  boundary_c
);
  localparam int unsigned ON_CYCLES = ROW_CYCLES - BLANK_CYCLES;
  localparam int unsigned TW        = $clog2(ROW_CYCLES);

  if (BLANK_CYCLES == 0 || BLANK_CYCLES >= ROW_CYCLES) begin : g_bad_blank
    $error("BLANK_CYCLES must be in 1..ROW_CYCLES-1");
  end

  logic [TW-1:0] timer;
  logic          blank_end_c;
  logic          on_end_c;

  assign blank_end_c = (state == BLANK) && (timer == TW'(BLANK_CYCLES - 1));
  assign on_end_c    = (state == ON) && (timer == TW'(ON_CYCLES - 1));
  // First cycle of row 0 blanking marks the frame boundary
  assign boundary_c  = (state == BLANK) && (row == '0) && (timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      timer <= '0;
      row   <= '0;
    end else if (blank_end_c) begin
      state <= ON;
      timer <= '0;
    end else if (on_end_c) begin
      state <= BLANK;
      timer <= '0;
      row   <= row + 1'b1;
    end else begin
      timer <= timer + 1'b1;
    end
  end

`ifdef LED_PWM_EN
  localparam int unsigned SLICE_LEN = ON_CYCLES >> SLICE_BITS;
  localparam int unsigned SW        = (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;

  if ((ON_CYCLES % (1 << SLICE_BITS)) != 0) begin : g_bad_on
    $error("ON_CYCLES must be a multiple of 2**PWM_BITS");
  end

  logic [SW-1:0] slice_timer;

  // Slice index advances every SLICE_LEN cycles of the ON phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_timer <= '0;
      slice       <= '0;
    end else if ((state == ON) && !on_end_c) begin
      if (slice_timer == SW'(SLICE_LEN - 1)) begin
        slice_timer <= '0;
        slice       <= slice + 1'b1;
      end else begin
        slice_timer <= slice_timer + 1'b1;
      end
    end else begin
      slice_timer <= '0;
      slice       <= '0;
    end
  end
`else
  assign slice = '0;
`endif
endmodule

// File: rtl/led_matrix_scan.sv
// 4x4 LED matrix display stage: frame handshake, double buffer and row scan decode.
// LED_PWM_EN selects PWM_BITS-bit brightness pixels; otherwise 1-bit on/off pixels.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 4096,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned PWM_BITS     = DEF_PWM_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
`ifdef LED_PWM_EN
  input  logic [PIXELS*PWM_BITS-1:0]          frame_data,
`else
  input  logic [PIXELS-1:0]                   frame_data,
`endif
  input  logic                                frame_valid,
  output logic                                frame_ready,
  output logic [ROWS-1:0]                     aled,
  output logic [COLS-1:0]                     kled_tri,
  output logic                                frame_sync
);
`ifdef LED_PWM_EN
  localparam int unsigned PIX_BITS = PWM_BITS;
`else
  localparam int unsigned PIX_BITS = 1;
`endif
  localparam int unsigned FW = PIXELS * PIX_BITS;

  if (PWM_BITS == 0) begin : g_bad_pwm
    $error("PWM_BITS must be nonzero");
  end

  scan_state_t         state;
  logic [ROW_W-1:0]    row;
  logic [PIX_BITS-1:0] slice;
  logic                boundary_c;
  logic [FW-1:0]       active;
  logic [FW-1:0]       shadow;
  logic                pending;
  logic                accept_c;
  logic [COLS-1:0]     lit_c;

  led_scan_timer #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .SLICE_BITS  (PIX_BITS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .row       (row),
    .slice     (slice),
    .boundary_c(boundary_c)
  );

  assign accept_c = frame_valid && frame_ready;

  // Shadow fills on accept; it moves to active only at a frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_ready <= 1'b1;
    end else begin
      if (boundary_c && pending) begin
        active      <= shadow;
        pending     <= 1'b0;
        frame_ready <= 1'b1;
      end
      if (accept_c) begin
        shadow      <= frame_data;
        pending     <= 1'b1;
        frame_ready <= 1'b0;
      end
    end
  end

  // A column is lit while its pixel value exceeds the current slice index
  always_comb begin
    lit_c = '0;
    for (int c = 0; c < COLS; c++) begin
      lit_c[c] = active[PIX_BITS*pixel_index(row, COL_W'(c)) +: PIX_BITS] > slice;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aled       <= '0;
      kled_tri   <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= boundary_c;
      if (state == ON) begin
        aled     <= ROWS'(1) << row;
        kled_tri <= lit_c;
      end else begin
        aled     <= '0;
        kled_tri <= '0;
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan; reduced row timing keeps runs short.
// Build with LED_PWM_EN to exercise the PWM brightness path.
module tb_led_matrix_scan;
  import led_matrix_pkg::*;

  localparam int unsigned ROW   = 512;
  localparam int unsigned BLK   = 16;
  localparam int unsigned ONC   = ROW - BLK;
  localparam int unsigned FRAME = ROWS * ROW;
  localparam int unsigned FW    = PIXELS * BPP;
`ifdef LED_PWM_EN
  localparam int unsigned SLICE = ONC >> BPP;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [FW-1:0]   frame_data = '0;
  logic            frame_valid = 1'b0;
  logic            frame_ready;
  logic [ROWS-1:0] aled;
  logic [COLS-1:0] kled_tri;
  logic            frame_sync;

  led_matrix_scan #(
    .ROW_CYCLES  (ROW),
    .BLANK_CYCLES(BLK),
    .PWM_BITS    (DEF_PWM_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .aled       (aled),
    .kled_tri   (kled_tri),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input logic [FW-1:0] f, input int r, input int c);
    return 32'(f[(r*COLS+c)*BPP +: BPP]);
  endfunction

  function automatic int exp_lit(input int p);
`ifdef LED_PWM_EN
    return p * SLICE;
`else
    return (p != 0) ? ONC : 0;
`endif
  endfunction

  // Scoreboard: accepted frames queue up and are shown from the next frame_sync
  logic [FW-1:0] sb_q[$];
  logic [FW-1:0] cur = '0;
  logic [FW-1:0] incoming_d = '0;
  bit              incoming = 0;
  bit              seen = 0;
  int              t = 0;
  int              row_i, off, p, aled_cnt, shape_err, rdy_err;
  int              lit_cnt[COLS];
  logic [ROWS-1:0] exp_a;
  logic [COLS-1:0] exp_k;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      cur = '0; incoming = 0; seen = 0; t = 0;
      aled_cnt = 0; shape_err = 0; rdy_err = 0;
      for (int c = 0; c < COLS; c++) lit_cnt[c] = 0;
    end else begin
      if (frame_sync) begin
        if (seen) check("sync_period", 64'(t + 1), 64'(FRAME));
        seen = 1;
        t = 0;
        if (sb_q.size() > 0) cur = sb_q.pop_front();
      end else begin
        t++;
      end
      if (incoming) sb_q.push_back(incoming_d);
      if (frame_ready !== (sb_q.size() == 0)) rdy_err++;
      incoming   = frame_valid && frame_ready;
      incoming_d = frame_data;

      if (!seen) begin
        check("pre_sync_dark", 64'({aled, kled_tri}), 64'(0));
      end else if (t >= FRAME) begin
        shape_err++;
      end else begin
        row_i = t / ROW;
        off   = t % ROW;
        exp_a = (off >= BLK) ? (ROWS'(1) << row_i) : '0;
        exp_k = '0;
        for (int c = 0; c < COLS; c++) begin
          p = pix(cur, row_i, c);
`ifdef LED_PWM_EN
          exp_k[c] = (off >= BLK) && (p > (off - BLK) / SLICE);
`else
          exp_k[c] = (off >= BLK) && (p != 0);
`endif
          if (kled_tri[c]) lit_cnt[c]++;
        end
        if (aled !== exp_a || kled_tri !== exp_k) shape_err++;
        if (aled === (ROWS'(1) << row_i)) aled_cnt++;
        if (off == ROW - 1) begin
          check($sformatf("row%0d_aled_on", row_i), 64'(aled_cnt), 64'(ONC));
          for (int c = 0; c < COLS; c++)
            check($sformatf("row%0d_col%0d_lit", row_i, c), 64'(lit_cnt[c]),
                  64'(exp_lit(pix(cur, row_i, c))));
          check($sformatf("row%0d_shape", row_i), 64'(shape_err), 64'(0));
          check("ready_track", 64'(rdy_err), 64'(0));
          aled_cnt = 0; shape_err = 0; rdy_err = 0;
          for (int c = 0; c < COLS; c++) lit_cnt[c] = 0;
        end
      end
    end
  end

  task automatic send_frame(input logic [FW-1:0] d, input int max_cyc, output bit sync_at);
    bit done = 0;
    sync_at = 0;
    frame_data  = d;
    frame_valid = 1'b1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (frame_ready) begin
        done    = 1;
        sync_at = frame_sync;
      end
      @(posedge clk); #1;
    end
    frame_valid = 1'b0;
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_sync(input int n);
    int got = 0;
    for (int i = 0; i < n * FRAME + ROW && got < n; i++) begin
      @(posedge clk); #1;
      if (frame_sync) got++;
    end
    if (got < n) check("sync_timeout", 64'(got), 64'(n));
  endtask

  logic [FW-1:0] frames[5];
  bit            s;

  initial begin
`ifdef LED_PWM_EN
    frames[0] = 64'h8F0F_F080_08F0_0F88;
    frames[1] = 64'hFFFF_8888_0000_F80F;
    frames[2] = 64'h0000_FFFF_8888_08F0;
    frames[3] = 64'hF0F0_0808_8F8F_FF00;
    frames[4] = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    frames[0] = 16'h8421;
    frames[1] = 16'h3C5A;
    frames[2] = 16'hA5C3;
    frames[3] = 16'h7E81;
    frames[4] = 16'hFFFF;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_aled", 64'(aled), 64'(0));
    check("rst_kled", 64'(kled_tri), 64'(0));
    check("rst_ready", 64'(frame_ready), 64'(1));
    check("rst_sync", 64'(frame_sync), 64'(0));
    rst = 1'b0;

    // Basic diagonal / mixed-brightness frame
    send_frame(frames[0], 8, s);
    check("ready_after_accept", 64'(frame_ready), 64'(0));
    wait_sync(2);

    // Backpressure: B stalls until the boundary that shows A
    send_frame(frames[1], 4, s);
    check("a_ready_drop", 64'(frame_ready), 64'(0));
    send_frame(frames[2], FRAME + ROW, s);
    check("b_accept_with_sync", 64'(s), 64'(1));
    check("b_ready_drop", 64'(frame_ready), 64'(0));
    wait_sync(2);

    // Boundary accept: offered during the frame_sync cycle itself
    check("bnd_sync", 64'(frame_sync), 64'(1));
    check("bnd_ready", 64'(frame_ready), 64'(1));
    frame_data  = frames[3];
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    check("bnd_ready_drop", 64'(frame_ready), 64'(0));
    wait_sync(2);

    // Mid-ON reset with a pending frame that must be discarded
    send_frame(frames[4], 4, s);
    repeat (ROW / 2) @(posedge clk);
    #3;
    check("pre_rst_on", 64'(aled), 64'(1));
    rst = 1'b1;
    #1;
    check("async_rst_aled", 64'(aled), 64'(0));
    check("async_rst_kled", 64'(kled_tri), 64'(0));
    check("async_rst_ready", 64'(frame_ready), 64'(1));
    check("async_rst_sync", 64'(frame_sync), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_sync(2);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
